// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and constants for register-file writeback arbitration
package rf_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_CSR = 2'd2
  } wb_src_e;

  // True when two or more bits are set: clearing the lowest set bit leaves something behind.
  function automatic logic more_than_one(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// rtl/rf_wb_arbiter_rr_pick.sv - combinational round-robin pick starting at a priority pointer
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  int               w_start;
  int               w_pos;
  logic [PTR_W-1:0] w_sel;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_pos   = 0;
    w_sel   = '0;
    // Out-of-range pointers cannot occur, but fall back to index 0 so the scan stays in range.
    w_start = (int'(ptr_i) < N) ? int'(ptr_i) : 0;
    for (int k = 0; k < N; k++) begin
      w_pos = w_start + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      w_sel = PTR_W'(w_pos);
      if (!valid_o && req_i[w_sel]) begin
        valid_o      = 1'b1;
        gnt_o[w_sel] = 1'b1;
        idx_o        = w_sel;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin arbiter sharing the register-file write port
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_ni,
  input  logic                      stall_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      we_o,
  output logic [ADDR_W-1:0]         waddr_o,
  output logic [DATA_W-1:0]         wdata_o,
  output logic                      conflict_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_conflict;

  logic [ADDR_W-1:0]  w_addr [NUM_REQ];
  logic [DATA_W-1:0]  w_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_req_eff;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_idx;
  logic               w_valid;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_multi;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g] = addr_i[g*ADDR_W +: ADDR_W];
    assign w_data[g] = data_i[g*DATA_W +: DATA_W];
  end

  // A stall masks every request, so no grant is issued and the pointer holds.
  assign w_req_eff = stall_i ? '0 : req_i;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (w_req_eff),
    .ptr_i   (r_ptr),
    .gnt_o   (w_gnt),
    .idx_o   (w_idx),
    .valid_o (w_valid)
  );

  assign w_sel_addr = w_addr[w_idx];
  assign w_sel_data = w_data[w_idx];
  assign w_ptr_nxt  = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
  assign w_multi    = more_than_one(32'(req_i));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_conflict <= 1'b0;
    end else if (w_valid) begin
      r_ptr      <= w_ptr_nxt;
      r_waddr    <= w_sel_addr;
      r_wdata    <= w_sel_data;
      // x0 is hardwired: the write is consumed but never reaches the register file.
      r_we       <= (w_sel_addr != '0);
      r_conflict <= w_multi;
    end else begin
      r_we       <= 1'b0;
      r_conflict <= 1'b0;
    end
  end

  assign gnt_o      = w_gnt;
  assign we_o       = r_we;
  assign waddr_o    = r_waddr;
  assign wdata_o    = r_wdata;
  assign conflict_o = r_conflict;

endmodule
